// File: rtl/chi_skew_interface.sv
// chi_skew_interface
//   Evaluates one WIDTH-bit Keccak chi row,
//     out[i] = a[i] ^ (~a[i+1] & a[i+2])   (indices mod WIDTH),
//   while each input bit reaches the chi core after its own programmable
//   delay in clock cycles. Every intermediate word applied to the core, and
//   the core's response to it, is visible on trace ports for leakage
//   evaluation.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; aborts any evaluation
//   cfg_we     load skew_cfg (accepted only while idle)
//   skew_cfg   field i (bits i*SKW_W +: SKW_W) = arrival skew of input bit i
//   in_valid   request to evaluate in
//   in         new chi input word
//   in_ready   high only while idle
//   core_in    skew-mixed word currently applied to chi (trace)
//   core_out   chi(core_in) (trace)
//   out_valid  one-cycle pulse, out holds a fresh result
//   out        chi(in) of the last completed evaluation
//   sample_cnt completed evaluations, saturating at 16'hFFFF
module chi_skew_interface #(
    parameter int WIDTH    = 5,
    parameter int MAX_SKEW = 3,
    parameter int SKW_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [WIDTH*SKW_W-1:0] skew_cfg,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       core_in,
    output logic [WIDTH-1:0]       core_out,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out,
    output logic [15:0]            sample_cnt
);

    // One extra bit over what MAX_SKEW needs, so the cycle counter never wraps.
    localparam int CNT_W = $clog2(MAX_SKEW + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SKEW_CAP = CNT_W'(MAX_SKEW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_r, state_next_s;
    logic [WIDTH-1:0]              prev_r, cur_r, out_r, core_in_s;
    logic [WIDTH-1:0][CNT_W-1:0]   skew_r, cfg_skew_s;
    logic [CNT_W-1:0]              max_skew_r, cfg_max_s, cnt_r;
    logic                          out_valid_r;
    logic [15:0]                   sample_cnt_r;

    function automatic logic [WIDTH-1:0] chi_f(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = a[i] ^ (~a[(i + 1) % WIDTH] & a[(i + 2) % WIDTH]);
        end
        return r;
    endfunction

    // Clamp each programmed skew field and find the largest clamped skew.
    always_comb begin
        cfg_skew_s = {(WIDTH*CNT_W){1'b0}};
        cfg_max_s  = CNT_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            if (32'(skew_cfg[i*SKW_W +: SKW_W]) > 32'(MAX_SKEW)) begin
                cfg_skew_s[i] = SKEW_CAP;
            end else begin
                cfg_skew_s[i] = CNT_W'(skew_cfg[i*SKW_W +: SKW_W]);
            end
            if (cfg_skew_s[i] > cfg_max_s) begin
                cfg_max_s = cfg_skew_s[i];
            end else begin
                cfg_max_s = cfg_max_s;
            end
        end
    end

    // Word seen by the chi core: a bit switches from its previous value to the
    // new one once the in-run cycle count reaches that bit's skew.
    always_comb begin
        core_in_s = prev_r;
        for (int i = 0; i < WIDTH; i++) begin
            if ((state_r == RUN) && (cnt_r >= skew_r[i])) begin
                core_in_s[i] = cur_r[i];
            end else begin
                core_in_s[i] = prev_r[i];
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == max_skew_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register; out_valid is registered so it is high exactly in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Datapath: skew configuration, operand capture, run counter, result and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r       <= {WIDTH{1'b0}};
            cur_r        <= {WIDTH{1'b0}};
            skew_r       <= {(WIDTH*CNT_W){1'b0}};
            max_skew_r   <= CNT_ZERO;
            cnt_r        <= CNT_ZERO;
            out_r        <= {WIDTH{1'b0}};
            sample_cnt_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    // Loading skews in the same cycle as a request applies them to it.
                    if (cfg_we) begin
                        skew_r     <= cfg_skew_s;
                        max_skew_r <= cfg_max_s;
                    end
                    if (in_valid) begin
                        cur_r <= in;
                        cnt_r <= CNT_ZERO;
                    end
                end
                RUN: begin
                    if (cnt_r == max_skew_r) begin
                        out_r <= chi_f(cur_r);
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    prev_r <= cur_r;
                    if (sample_cnt_r != 16'hFFFF) begin
                        sample_cnt_r <= sample_cnt_r + 16'h0001;
                    end
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign in_ready   = (state_r == IDLE);
    assign core_in    = core_in_s;
    assign core_out   = chi_f(core_in_s);
    assign out_valid  = out_valid_r;
    assign out        = out_r;
    assign sample_cnt = sample_cnt_r;

endmodule
